// File: rtl/cmdparser_pkg.sv
// Shared definitions for the burst command parser: opcode bytes and FSM states.
package cmdparser_pkg;

    localparam logic [7:0] OP_RD  = 8'h55;
    localparam logic [7:0] OP_WR  = 8'hAA;
    localparam logic [7:0] OP_BRD = 8'h5A;
    localparam logic [7:0] OP_BWR = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_COUNT,
        ST_WDATA,
        ST_WRITE,
        ST_READ,
        ST_RWAIT,
        ST_RESP
    } state_t;

endpackage

// File: rtl/cmdparser_bytepack.sv
// Byte<->word shift register: bytes enter at the top and move down, so a word
// assembles little-endian and serialises LSB first from word[7:0].
module cmdparser_bytepack #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic         load,
    input  logic [W-1:0] load_word,
    input  logic         shift,
    input  logic [7:0]   in_byte,
    output logic [W-1:0] word
);

    logic [W-1:0] shifted;

    generate
        if (W == 8) begin : g_byte
            assign shifted = in_byte;
        end else begin : g_wide
            assign shifted = {in_byte, word[W-1:8]};
        end
    endgenerate

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            word <= '0;
        end else if (load) begin
            word <= load_word;
        end else if (shift) begin
            word <= shifted;
        end
    end

endmodule

// File: rtl/cmdparser_burst.sv
// Byte-stream command parser with burst read/write and a backpressured response stream.
// Optional partial-command abort after TIMEOUT idle cycles: define CMDPARSER_TIMEOUT_EN.
module cmdparser_burst
    import cmdparser_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ack,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              err
);

    localparam logic [1:0] A_LAST = 2'(ADDR_W / 8 - 1);
    localparam logic [1:0] D_LAST = 2'(DATA_W / 8 - 1);

    generate
        if (ADDR_W % 8 != 0 || ADDR_W < 8 || ADDR_W > 32) begin : g_bad_addr_w
            $error("ADDR_W must be a multiple of 8 in 8..32");
        end
        if (DATA_W % 8 != 0 || DATA_W < 8 || DATA_W > 32) begin : g_bad_data_w
            $error("DATA_W must be a multiple of 8 in 8..32");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("TIMEOUT must be at least 1");
        end
    endgenerate

    state_t            state, state_n;
    logic [1:0]        idx;
    logic [8:0]        cnt;
    logic              op_rd, op_burst;
    logic [DATA_W-1:0] data_word, wdata_q;
    logic              err_n;
    logic              addr_shift, addr_inc, data_shift, data_load;
    logic              idx_clr, idx_inc, op_cap, cnt_one, cnt_ld, cnt_dec;

    cmdparser_bytepack #(.W(ADDR_W)) u_addr (
        .clk       (clk),
        .nreset    (nreset),
        .load      (addr_inc),
        .load_word (bus_addr + ADDR_W'(1)),
        .shift     (addr_shift),
        .in_byte   (in_data),
        .word      (bus_addr)
    );

    // Shared between write-word assembly and read-word serialisation.
    cmdparser_bytepack #(.W(DATA_W)) u_data (
        .clk       (clk),
        .nreset    (nreset),
        .load      (data_load),
        .load_word (bus_rdata),
        .shift     (data_shift),
        .in_byte   (in_data),
        .word      (data_word)
    );

`ifdef CMDPARSER_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo;
    logic             stall, abort;

    assign stall = (state == ST_ADDR || state == ST_COUNT || state == ST_WDATA) && !in_valid;
    assign abort = stall && (tmo == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tmo <= '0;
        end else if (stall && !abort) begin
            tmo <= tmo + TMO_W'(1);
        end else begin
            tmo <= '0;
        end
    end
`endif

    always_comb begin
        state_n    = state;
        in_ack     = 1'b0;
        bus_wr     = 1'b0;
        bus_rd     = 1'b0;
        out_valid  = 1'b0;
        err_n      = 1'b0;
        addr_shift = 1'b0;
        addr_inc   = 1'b0;
        data_shift = 1'b0;
        data_load  = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        op_cap     = 1'b0;
        cnt_one    = 1'b0;
        cnt_ld     = 1'b0;
        cnt_dec    = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ack  = in_valid;
                idx_clr = 1'b1;
                if (in_valid) begin
                    if (in_data == OP_RD || in_data == OP_WR ||
                        in_data == OP_BRD || in_data == OP_BWR) begin
                        op_cap  = 1'b1;
                        state_n = ST_ADDR;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_ADDR: begin
                in_ack = in_valid;
                if (in_valid) begin
                    addr_shift = 1'b1;
                    idx_inc    = 1'b1;
                    if (idx == A_LAST) begin
                        idx_clr = 1'b1;
                        if (op_burst) begin
                            state_n = ST_COUNT;
                        end else begin
                            cnt_one = 1'b1;
                            state_n = op_rd ? ST_READ : ST_WDATA;
                        end
                    end
                end
            end
            ST_COUNT: begin
                in_ack = in_valid;
                if (in_valid) begin
                    cnt_ld  = 1'b1;
                    state_n = op_rd ? ST_READ : ST_WDATA;
                end
            end
            ST_WDATA: begin
                in_ack = in_valid;
                if (in_valid) begin
                    data_shift = 1'b1;
                    idx_inc    = 1'b1;
                    if (idx == D_LAST) begin
                        idx_clr = 1'b1;
                        state_n = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                bus_wr   = 1'b1;
                addr_inc = 1'b1;
                cnt_dec  = 1'b1;
                state_n  = (cnt == 9'd1) ? ST_IDLE : ST_WDATA;
            end
            ST_READ: begin
                bus_rd  = 1'b1;
                state_n = ST_RWAIT;
            end
            ST_RWAIT: begin
                data_load = 1'b1;
                idx_clr   = 1'b1;
                state_n   = ST_RESP;
            end
            ST_RESP: begin
                // Next read is only issued once the whole word has drained.
                out_valid = 1'b1;
                if (out_ready) begin
                    data_shift = 1'b1;
                    idx_inc    = 1'b1;
                    if (idx == D_LAST) begin
                        idx_clr  = 1'b1;
                        addr_inc = 1'b1;
                        cnt_dec  = 1'b1;
                        state_n  = (cnt == 9'd1) ? ST_IDLE : ST_READ;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
`ifdef CMDPARSER_TIMEOUT_EN
        if (abort) begin
            state_n = ST_IDLE;
            err_n   = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state    <= ST_IDLE;
            idx      <= '0;
            cnt      <= '0;
            op_rd    <= 1'b0;
            op_burst <= 1'b0;
            wdata_q  <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_n;
            err   <= err_n;
            if (idx_clr) begin
                idx <= '0;
            end else if (idx_inc) begin
                idx <= idx + 2'd1;
            end
            if (op_cap) begin
                op_rd    <= (in_data == OP_RD) || (in_data == OP_BRD);
                op_burst <= (in_data == OP_BRD) || (in_data == OP_BWR);
            end
            if (cnt_one) begin
                cnt <= 9'd1;
            end else if (cnt_ld) begin
                cnt <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            end else if (cnt_dec) begin
                cnt <= cnt - 9'd1;
            end
            if (state == ST_WRITE) begin
                wdata_q <= data_word;
            end
        end
    end

    assign bus_wdata = (state == ST_WRITE) ? data_word : wdata_q;
    assign out_data  = (state == ST_RESP) ? data_word[7:0] : 8'd0;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_cmdparser_burst.sv
// Bench for cmdparser_burst: an 8/8 and a 16/16 instance share the byte stream,
// each backed by its own register bank, checked against a command-level model.
module tb_cmdparser_burst;

    localparam int unsigned TMO    = 32;
    localparam int unsigned BUDGET = 5000;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        nreset, in_valid, out_ready, sel;
    logic [7:0]  in_data;

    logic        ack8, rd8, wr8, ov8, busy8, err8;
    logic [7:0]  addr8, wdata8, rdata8, od8;
    logic        ack16, rd16, wr16, ov16, busy16, err16;
    logic [15:0] addr16, wdata16, rdata16;
    logic [7:0]  od16;

    logic        m_ack, m_wr, m_rd, m_ov, m_busy, m_err;
    logic [7:0]  m_od;
    logic [31:0] m_addr, m_wdata;

    logic [7:0]  bank8[256], ref8[256];
    logic [15:0] bank16[65536], ref16[65536];

    wr_t         exp_wr[$], obs_wr[$];
    logic [7:0]  exp_resp[$], obs_resp[$], cmd[$];
    int          exp_err;
    logic [31:0] exp_addr[2], exp_wdata[2];

    int          n_assert = 0, n_fail = 0;
    int          rmode = 2;
    int unsigned clr_req = 0, clr_seen = 0;
    int          obs_err, rd_out, ovl_bad, stab_bad, biw;
    logic        pv, pr;
    logic [7:0]  pd;

    always #5 clk = ~clk;

    cmdparser_burst #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TMO)) dut8 (
        .clk(clk), .nreset(nreset), .in_data(in_data), .in_valid(in_valid & ~sel),
        .in_ack(ack8), .bus_addr(addr8), .bus_wdata(wdata8), .bus_rdata(rdata8),
        .bus_rd(rd8), .bus_wr(wr8), .out_data(od8), .out_valid(ov8),
        .out_ready(out_ready), .busy(busy8), .err(err8)
    );

    cmdparser_burst #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(TMO)) dut16 (
        .clk(clk), .nreset(nreset), .in_data(in_data), .in_valid(in_valid & sel),
        .in_ack(ack16), .bus_addr(addr16), .bus_wdata(wdata16), .bus_rdata(rdata16),
        .bus_rd(rd16), .bus_wr(wr16), .out_data(od16), .out_valid(ov16),
        .out_ready(out_ready), .busy(busy16), .err(err16)
    );

    always_comb begin
        m_ack   = sel ? ack16  : ack8;
        m_wr    = sel ? wr16   : wr8;
        m_rd    = sel ? rd16   : rd8;
        m_ov    = sel ? ov16   : ov8;
        m_busy  = sel ? busy16 : busy8;
        m_err   = sel ? err16  : err8;
        m_od    = sel ? od16   : od8;
        m_addr  = sel ? 32'(addr16)  : 32'(addr8);
        m_wdata = sel ? 32'(wdata16) : 32'(wdata8);
    end

    // Register banks: read data appears one cycle after bus_rd.
    always @(posedge clk) begin
        if (wr8)  bank8[addr8]   <= wdata8;
        if (rd8)  rdata8         <= bank8[addr8];
        if (wr16) bank16[addr16] <= wdata16;
        if (rd16) rdata16        <= bank16[addr16];
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(negedge clk);
            case (rmode)
                0:       out_ready = 1'($urandom_range(0, 1));
                1:       out_ready = ~out_ready;
                default: out_ready = 1'b1;
            endcase
        end
    end

    // Monitor samples one time unit before each rising edge.
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (clr_req != clr_seen) begin
                clr_seen = clr_req;
                obs_wr.delete();
                obs_resp.delete();
                obs_err = 0; rd_out = 0; ovl_bad = 0; stab_bad = 0; biw = 0; pv = 1'b0;
            end
            if (m_wr) obs_wr.push_back('{m_addr, m_wdata});
            if (m_rd) begin
                rd_out++;
                if (rd_out > 1) ovl_bad++;
            end
            if (m_err) obs_err++;
            if (pv && !pr && (!m_ov || m_od !== pd)) stab_bad++;
            if (m_ov && out_ready) begin
                obs_resp.push_back(m_od);
                biw++;
                if (biw == (sel ? 2 : 1)) begin
                    biw = 0;
                    rd_out--;
                end
            end
            pv = m_ov; pr = out_ready; pd = m_od;
        end
    end

    function automatic logic is_op(input logic [7:0] b);
        return b == 8'h55 || b == 8'hAA || b == 8'h5A || b == 8'hA5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Command-level reference: decodes cmd[] and predicts writes, response bytes, err.
    task automatic model(input logic s);
        int unsigned nab = s ? 2 : 1;
        int unsigned n, p;
        logic [31:0] amask = s ? 32'hFFFF : 32'hFF;
        logic [31:0] a, d;
        logic [7:0]  op;
        exp_wr.delete();
        exp_resp.delete();
        exp_err = 0;
        op = cmd[0];
        if (!is_op(op)) begin
            exp_err = 1;
            return;
        end
        a = 0;
        for (int unsigned i = 0; i < nab; i++) a |= 32'(cmd[1 + i]) << (8 * i);
        p = 1 + nab;
        if (op == 8'h5A || op == 8'hA5) begin
            n = (cmd[p] == 8'd0) ? 256 : int'(cmd[p]);
            p++;
        end else begin
            n = 1;
        end
        for (int unsigned k = 0; k < n; k++) begin
            if (op == 8'hAA || op == 8'hA5) begin
                d = 0;
                for (int unsigned i = 0; i < nab; i++) d |= 32'(cmd[p + i]) << (8 * i);
                p += nab;
                exp_wr.push_back('{a, d});
                if (s) ref16[a[15:0]] = d[15:0];
                else   ref8[a[7:0]]   = d[7:0];
                exp_wdata[s] = d;
            end else begin
                d = s ? 32'(ref16[a[15:0]]) : 32'(ref8[a[7:0]]);
                for (int unsigned i = 0; i < nab; i++) exp_resp.push_back(d[8*i +: 8]);
            end
            a = (a + 1) & amask;
        end
        exp_addr[s] = a;
    endtask

    task automatic gen_cmd(input logic s);
        int unsigned nab = s ? 2 : 1;
        int unsigned n;
        logic [7:0]  op, c;
        cmd.delete();
        case ($urandom_range(0, 8))
            0: begin
                op = 8'($urandom);
                while (is_op(op)) op = 8'($urandom);
            end
            1, 2:    op = 8'h55;
            3, 4:    op = 8'hAA;
            5, 6:    op = 8'h5A;
            default: op = 8'hA5;
        endcase
        cmd.push_back(op);
        if (!is_op(op)) return;
        for (int unsigned i = 0; i < nab; i++) cmd.push_back(8'($urandom));
        n = 1;
        if (op == 8'h5A || op == 8'hA5) begin
            c = ($urandom_range(0, 11) == 0) ? 8'd0 : 8'($urandom_range(1, 5));
            cmd.push_back(c);
            n = (c == 8'd0) ? 256 : int'(c);
        end
        if (op == 8'hAA || op == 8'hA5)
            for (int unsigned k = 0; k < n * nab; k++) cmd.push_back(8'($urandom));
    endtask

    task automatic send_byte(input logic [7:0] b, inout logic tmo);
        int unsigned w = 0;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        forever begin
            #4;
            if (m_ack) break;
            w++;
            if (w > BUDGET) begin
                tmo = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic run_cmd(input logic s, input string tag);
        int unsigned w;
        logic tmo = 1'b0;
        sel = s;
        model(s);
        clr_req++;
        foreach (cmd[i]) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                in_valid = 1'b0;
            end
            send_byte(cmd[i], tmo);
            if (tmo) break;
        end
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (!tmo) begin
            #4;
            if (!m_busy) break;
            w++;
            if (w > BUDGET) tmo = 1'b1;
            else @(negedge clk);
        end
        repeat (3) @(negedge clk);
        chk({tag, ".no_hang"}, 32'(tmo), 0);
        chk({tag, ".n_wr"}, obs_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < obs_wr.size(); i++) begin
            chk($sformatf("%s.wr%0d.addr", tag, i), obs_wr[i].a, exp_wr[i].a);
            chk($sformatf("%s.wr%0d.data", tag, i), obs_wr[i].d, exp_wr[i].d);
        end
        chk({tag, ".n_resp"}, obs_resp.size(), exp_resp.size());
        for (int i = 0; i < exp_resp.size() && i < obs_resp.size(); i++)
            chk($sformatf("%s.resp%0d", tag, i), 32'(obs_resp[i]), 32'(exp_resp[i]));
        chk({tag, ".err"}, obs_err, exp_err);
        chk({tag, ".rd_outstanding"}, ovl_bad, 0);
        chk({tag, ".out_stable"}, stab_bad, 0);
        chk({tag, ".busy"}, 32'(m_busy), 0);
        chk({tag, ".addr_hold"}, m_addr, exp_addr[s]);
        chk({tag, ".wdata_hold"}, m_wdata, exp_wdata[s]);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, ".in_ack"}, 32'(ack8), 0);
        chk({tag, ".bus_addr"}, 32'(addr8), 0);
        chk({tag, ".bus_wdata"}, 32'(wdata8), 0);
        chk({tag, ".bus_rd"}, 32'(rd8), 0);
        chk({tag, ".bus_wr"}, 32'(wr8), 0);
        chk({tag, ".out_data"}, 32'(od8), 0);
        chk({tag, ".out_valid"}, 32'(ov8), 0);
        chk({tag, ".busy"}, 32'(busy8), 0);
        chk({tag, ".err"}, 32'(err8), 0);
    endtask

    initial begin
        logic tmo;
        for (int i = 0; i < 256; i++) bank8[i] = 8'(i * 7 + 3);
        bank8[8'hAB] = 8'h10;
        for (int i = 0; i < 65536; i++) bank16[i] = 16'(i) ^ 16'h5A5A;
        ref8  = bank8;
        ref16 = bank16;
        exp_addr[0] = 0;  exp_addr[1] = 0;
        exp_wdata[0] = 0; exp_wdata[1] = 0;
        nreset = 1'b0; in_valid = 1'b0; in_data = 8'd0; sel = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle_outs("reset");
        nreset = 1'b1;

        cmd = '{8'h55, 8'hAB};                         run_cmd(0, "rd_reset_val");
        cmd = '{8'hAA, 8'hAB, 8'h50};                  run_cmd(0, "wr_single");
        cmd = '{8'h55, 8'hAB};                         run_cmd(0, "rd_back");
        cmd = '{8'hA5, 8'hFE, 8'h03, 8'h11, 8'h22, 8'h33}; run_cmd(0, "bwr_wrap");
        rmode = 1;
        cmd = '{8'h5A, 8'h10, 8'h04};                  run_cmd(0, "brd_toggle");
        rmode = 2;
        cmd = '{8'hAA, 8'h34, 8'h12, 8'hCD, 8'hAB};    run_cmd(1, "wr16");
        cmd = '{8'h55, 8'h34, 8'h12};                  run_cmd(1, "rd16");
        cmd = '{8'h77};                                run_cmd(0, "bad_op");

        rmode = 0;
        for (int t = 0; t < 30; t++) begin
            logic s;
            s = 1'($urandom_range(0, 1));
            gen_cmd(s);
            run_cmd(s, $sformatf("rand%0d", t));
        end
        rmode = 2;

`ifdef CMDPARSER_TIMEOUT_EN
        sel = 1'b0;
        clr_req++;
        tmo = 1'b0;
        send_byte(8'hAA, tmo);
        send_byte(8'hAB, tmo);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (TMO + 5) @(negedge clk);
        chk("timeout.no_hang", 32'(tmo), 0);
        chk("timeout.err", obs_err, 1);
        chk("timeout.n_wr", obs_wr.size(), 0);
        chk("timeout.busy", 32'(m_busy), 0);
`endif

        sel = 1'b0;
        clr_req++;
        tmo = 1'b0;
        cmd = '{8'hA5, 8'h20, 8'h05, 8'h01, 8'h02};
        foreach (cmd[i]) send_byte(cmd[i], tmo);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        nreset   = 1'b0;
        #1;
        chk("rst_mid.no_hang", 32'(tmo), 0);
        chk_idle_outs("rst_mid");
        clr_req++;
        @(negedge clk);
        nreset = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_mid.no_wr_after", obs_wr.size(), 0);
        chk("rst_mid.busy_after", 32'(busy8), 0);
        chk("rst_mid.first_word_kept", 32'(bank8[8'h20]), 32'h01);
        chk("rst_mid.second_dropped", 32'(bank8[8'h21]), 32'(ref8[8'h21]));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
